// File: rtl/seq_subtractor_if.sv
// Operand/result handshake bundle for seq_subtractor.
// master: producer/consumer side; slave: the subtractor.
interface seq_subtractor_if #(
   parameter int N = 32
) ();
   logic         in_valid;
   logic         in_ready;
   logic [N-1:0] a;
   logic [N-1:0] b;
   logic         b_in;
   logic         out_valid;
   logic         out_ready;
   logic [N-1:0] d;
   logic         b_out;
   logic         ovf;

   modport master (
      output in_valid, a, b, b_in, out_ready,
      input  in_ready, out_valid, d, b_out, ovf
   );

   modport slave (
      input  in_valid, a, b, b_in, out_ready,
      output in_ready, out_valid, d, b_out, ovf
   );
endinterface

// File: rtl/seq_subtractor.sv
// Multi-cycle subtractor: d = a - b - b_in, one W-bit chunk per cycle.
// Ports: clk, reset (sync, active-high), bus (seq_subtractor_if.slave).
module seq_subtractor #(
   parameter int N = 32,
   parameter int W = 8
) (
   input  logic              clk,
   input  logic              reset,
   seq_subtractor_if.slave   bus
);
   localparam int C  = N / W;
   localparam int KW = (C > 1) ? $clog2(C) : 1;
   localparam logic [KW-1:0] LAST = KW'(C - 1);

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } state_t;

   state_t        state_q, state_d;
   logic          in_ready_q, in_ready_d;
   logic          out_valid_q, out_valid_d;
   logic [N-1:0]  a_q, a_d;
   logic [N-1:0]  b_q, b_d;
   logic [N-1:0]  res_q, res_d;
   logic [KW-1:0] k_q, k_d;
   logic          borrow_q, borrow_d;
   logic [N-1:0]  d_q, d_d;
   logic          b_out_q, b_out_d;
   logic          ovf_q, ovf_d;

   int            lo;
   logic [W-1:0]  a_k;
   logic [W-1:0]  b_k;
   logic [W:0]    sub;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         a_q         <= '0;
         b_q         <= '0;
         res_q       <= '0;
         k_q         <= '0;
         borrow_q    <= 1'b0;
         d_q         <= '0;
         b_out_q     <= 1'b0;
         ovf_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         a_q         <= a_d;
         b_q         <= b_d;
         res_q       <= res_d;
         k_q         <= k_d;
         borrow_q    <= borrow_d;
         d_q         <= d_d;
         b_out_q     <= b_out_d;
         ovf_q       <= ovf_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      in_ready_d  = in_ready_q;
      out_valid_d = out_valid_q;
      a_d         = a_q;
      b_d         = b_q;
      res_d       = res_q;
      k_d         = k_q;
      borrow_d    = borrow_q;
      d_d         = d_q;
      b_out_d     = b_out_q;
      ovf_d       = ovf_q;

      // current chunk; the extra top bit of sub is the borrow out
      lo  = int'(k_q) * W;
      a_k = a_q[lo +: W];
      b_k = b_q[lo +: W];
      sub = {1'b0, a_k} - {1'b0, b_k} - {{W{1'b0}}, borrow_q};

      unique case (state_q)
         IDLE: begin
            in_ready_d = 1'b1;
            if (bus.in_valid && in_ready_q) begin
               a_d        = bus.a;
               b_d        = bus.b;
               borrow_d   = bus.b_in;
               k_d        = '0;
               in_ready_d = 1'b0;
               state_d    = BUSY;
            end
         end
         BUSY: begin
            res_d[lo +: W] = sub[W-1:0];
            borrow_d       = sub[W];
            if (k_q == LAST) begin
               // publish the whole result at once so d is never partial
               d_d         = res_d;
               b_out_d     = sub[W];
               ovf_d       = (a_q[N-1] != b_q[N-1]) &&
                             (res_d[N-1] != a_q[N-1]);
               out_valid_d = 1'b1;
               state_d     = DONE;
            end else begin
               k_d = k_q + KW'(1);
            end
         end
         DONE: begin
            if (out_valid_q && bus.out_ready) begin
               out_valid_d = 1'b0;
               in_ready_d  = 1'b1;
               state_d     = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.d         = d_q;
   assign bus.b_out     = b_out_q;
   assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_seq_subtractor.sv
// Directed, table-driven bench for seq_subtractor (N=32, W=8).
// Checks latency, results, backpressure and reset abort.
module tb_seq_subtractor;
   localparam int N = 32;
   localparam int W = 8;

   typedef struct {
      logic [N-1:0] a;
      logic [N-1:0] b;
      logic         bin;
      logic [N-1:0] d;
      logic         bout;
      logic         ovf;
   } vec_t;

   logic clk;
   logic reset;
   int   n_checks;
   int   n_fail;

   seq_subtractor_if #(.N(N)) bus ();

   seq_subtractor #(.N(N), .W(W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name,
                        input logic [63:0] act,
                        input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // accept, wait for out_valid, check, then complete the handshake
   task automatic run_op(input vec_t v, input string tag);
      int cyc;
      bus.a        = v.a;
      bus.b        = v.b;
      bus.b_in     = v.bin;
      bus.in_valid = 1'b1;
      check({tag, " in_ready"}, 64'(bus.in_ready), 64'd1);
      tick();
      bus.in_valid = 1'b0;
      check({tag, " in_ready busy"}, 64'(bus.in_ready), 64'd0);
      cyc = 0;
      while (cyc < 10) begin
         tick();
         cyc++;
         if (bus.out_valid) break;
      end
      check({tag, " latency"}, 64'(cyc), 64'd4);
      check({tag, " d"}, 64'(bus.d), 64'(v.d));
      check({tag, " b_out"}, 64'(bus.b_out), 64'(v.bout));
      check({tag, " ovf"}, 64'(bus.ovf), 64'(v.ovf));
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      check({tag, " out_valid drop"}, 64'(bus.out_valid), 64'd0);
      check({tag, " in_ready back"}, 64'(bus.in_ready), 64'd1);
      check({tag, " d held"}, 64'(bus.d), 64'(v.d));
   endtask

   vec_t vecs[9];
   vec_t v;
   logic [N-1:0] held;

   initial begin
      n_checks = 0;
      n_fail   = 0;
      vecs[0] = '{32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0002, 1'b0, 1'b0};
      vecs[1] = '{32'h0000_0000, 32'h0000_0001, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0};
      vecs[2] = '{32'h0000_0100, 32'h0000_00FF, 1'b1, 32'h0000_0000, 1'b0, 1'b0};
      vecs[3] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1};
      vecs[4] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 1'b1, 1'b1};
      vecs[5] = '{32'h1234_5678, 32'h1234_5678, 1'b0, 32'h0000_0000, 1'b0, 1'b0};
      vecs[6] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
      vecs[7] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0};
      vecs[8] = '{32'h0001_0000, 32'h0000_0001, 1'b0, 32'h0000_FFFF, 1'b0, 1'b0};

      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      bus.a         = '0;
      bus.b         = '0;
      bus.b_in      = 1'b0;
      reset         = 1'b1;

      for (int i = 0; i < 3; i++) begin
         tick();
         check("rst in_ready", 64'(bus.in_ready), 64'd0);
         check("rst out_valid", 64'(bus.out_valid), 64'd0);
         check("rst d", 64'(bus.d), 64'd0);
         check("rst b_out", 64'(bus.b_out), 64'd0);
         check("rst ovf", 64'(bus.ovf), 64'd0);
      end
      reset = 1'b0;
      tick();
      check("post-rst in_ready", 64'(bus.in_ready), 64'd1);

      for (int i = 0; i < 9; i++) begin
         run_op(vecs[i], $sformatf("vec%0d", i));
      end

      // backpressure: DONE held with new operands offered
      v = '{32'h1000_0000, 32'h0000_0001, 1'b0, 32'h0FFF_FFFF, 1'b0, 1'b0};
      bus.a        = v.a;
      bus.b        = v.b;
      bus.b_in     = v.bin;
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      check("bp out_valid", 64'(bus.out_valid), 64'd1);
      held = bus.d;
      check("bp d", 64'(held), 64'(v.d));
      bus.a        = 32'h0000_0000;
      bus.b        = 32'h0000_0001;
      bus.b_in     = 1'b1;
      bus.in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("bp hold valid", 64'(bus.out_valid), 64'd1);
         check("bp hold d", 64'(bus.d), 64'(v.d));
         check("bp hold b_out", 64'(bus.b_out), 64'(v.bout));
         check("bp hold ovf", 64'(bus.ovf), 64'(v.ovf));
         check("bp in_ready", 64'(bus.in_ready), 64'd0);
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      check("bp done in_ready", 64'(bus.in_ready), 64'd1);
      check("bp done d", 64'(bus.d), 64'(v.d));
      for (int i = 0; i < 6; i++) tick();
      check("bp no queued op", 64'(bus.out_valid), 64'd0);
      check("bp no queued d", 64'(bus.d), 64'(v.d));

      // abort: reset during the second BUSY cycle
      bus.a        = 32'h0000_0005;
      bus.b        = 32'h0000_0003;
      bus.b_in     = 1'b0;
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      tick();
      reset = 1'b1;
      tick();
      check("abort out_valid", 64'(bus.out_valid), 64'd0);
      check("abort d", 64'(bus.d), 64'd0);
      check("abort in_ready", 64'(bus.in_ready), 64'd0);
      reset = 1'b0;
      tick();
      check("abort in_ready back", 64'(bus.in_ready), 64'd1);
      for (int i = 0; i < 6; i++) begin
         tick();
         check("abort no result", 64'(bus.out_valid), 64'd0);
      end
      check("abort d stays", 64'(bus.d), 64'd0);

      run_op(vecs[3], "recover");

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/seq_subtractor.md
# seq_subtractor

Multi-cycle N-bit two's-complement subtractor. It computes d = a − b − b_in one W-bit chunk per cycle, LSB chunk first, and registers the inter-chunk borrow. Operands come in and results go out over valid/ready handshakes. It is the subtract-side companion to the combinational adders in the arithmetic library, for datapaths that trade latency for a short borrow chain per cycle.

## Interface
Parameters:
- N, 32, operand/result width; must be a positive multiple of W
- W, 8, chunk width processed per cycle; N/W = number of chunks (C)

Ports:
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  operands a, b, b_in are valid
- in_ready  output  1  block can accept operands (registered)
- a  input  N  minuend
- b  input  N  subtrahend
- b_in  input  1  borrow in
- out_valid  output  1  result d, b_out, ovf valid (registered)
- out_ready  input  1  consumer takes result
- d  output  N  difference, (a − b − b_in) mod 2^N
- b_out  output  1  unsigned borrow out: 1 iff a < b + b_in
- ovf  output  1  signed overflow: (a[N-1] != b[N-1]) && (d[N-1] != a[N-1])

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE: in_ready = 1.
  - On in_valid && in_ready, latch a, b, b_in into working registers.
  - Clear the chunk counter k to 0, seed the borrow register with b_in, and go to BUSY.
- BUSY: in_ready = 0. Each cycle:
  - Compute {borrow_next, diff_k} = a_k − b_k − borrow as a W-bit subtract, where a_k and b_k are bits [k*W +: W].
  - Store diff_k into the working result and update the borrow register.
  - Increment k.
  - After chunk C−1, go to DONE.
- DONE entry: load d with the full working result and b_out with the final borrow. Compute ovf from latched a[N-1], b[N-1] and the new d[N-1]. Assert out_valid.
- DONE: hold d, b_out, ovf and out_valid stable until out_ready. On out_valid && out_ready, go to IDLE.
- d, b_out and ovf change only on DONE entry or reset. They hold the last result after the handshake and are never partially updated while visible.
- in_valid is ignored in BUSY and DONE; operands are not queued.
- The chunk counter is wide enough for C−1 and wraps to 0 only via IDLE acceptance. When N == W, C = 1 and BUSY lasts exactly one cycle.

## Timing
- Reset (clk edge with reset = 1): state IDLE, in_ready = 0, out_valid = 0, d = 0, b_out = 0, ovf = 0, working registers and counter = 0.
- First cycle after reset deasserts: in_ready = 1.
- Accept at edge t. Chunks are registered at edges t+1 … t+C. out_valid is high from the cycle following edge t+C, so latency is C cycles from accept to out_valid.
- Result taken at edge u (out_ready = 1 while out_valid = 1): out_valid = 0 and in_ready = 1 from the cycle after u.
- Minimum issue interval is C+2 cycles (accept, C BUSY cycles, DONE with out_ready held high).
- If out_ready is already high when out_valid rises, the handshake completes at the first DONE edge.
- Reset mid-BUSY or mid-DONE aborts the operation. The pending result is discarded, outputs return to reset values, and in_ready = 1 the cycle after reset deasserts.
- The concurrent in_valid/out_ready case cannot occur, because in_ready = 0 whenever out_valid = 1.

## Test plan
All cases use N = 32, W = 8, C = 4.
- Reset: hold reset 3 cycles, then release → in_ready = 0 and all outputs = 0 during reset; in_ready = 1 on the first cycle after release.
- Basic subtract: a = 0x0000_0005, b = 0x0000_0003, b_in = 0 → out_valid exactly 4 cycles after accept; d = 0x0000_0002, b_out = 0, ovf = 0.
- Full borrow ripple: a = 0x0000_0000, b = 0x0000_0001, b_in = 0 → d = 0xFFFF_FFFF, b_out = 1, ovf = 0.
- Chunk-boundary borrow with b_in: a = 0x0000_0100, b = 0x0000_00FF, b_in = 1 → d = 0x0000_0000, b_out = 0, ovf = 0.
- Signed overflow, both directions:
  - 0x8000_0000 − 0x0000_0001 → d = 0x7FFF_FFFF, b_out = 0, ovf = 1.
  - 0x7FFF_FFFF − 0xFFFF_FFFF → d = 0x8000_0000, b_out = 1, ovf = 1.
- Backpressure and abort:
  - Hold out_ready = 0 for 5 cycles in DONE while driving in_valid = 1 with new operands → d, b_out, ovf stable; in_ready = 0; the new operands are never accepted.
  - Next op: assert reset in the 2nd BUSY cycle → out_valid never rises; d = 0; in_ready = 1 one cycle after release.
